// File: rtl/vc_crossbar3_arb.sv
// Control stage ahead of a 3x3 crossbar: per-output round-robin arbitration
// with sticky grants, val/rdy handshakes and crossbar select generation.
module vc_crossbar3_arb #(
  parameter int p_num_ports = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_val,
  input  logic       in1_val,
  input  logic       in2_val,
  input  logic [1:0] in0_dest,
  input  logic [1:0] in1_dest,
  input  logic [1:0] in2_dest,
  output logic       in0_rdy,
  output logic       in1_rdy,
  output logic       in2_rdy,
  output logic       out0_val,
  output logic       out1_val,
  output logic       out2_val,
  input  logic       out0_rdy,
  input  logic       out1_rdy,
  input  logic       out2_rdy,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2
);

  if (p_num_ports != 3) begin : g_bad_ports
    $error("vc_crossbar3_arb supports only p_num_ports == 3");
  end

  logic [2:0]      val_s;
  logic [2:0][1:0] dest_s;
  logic [2:0]      out_rdy_s;
  logic [2:0][3:0] req_s;      // req_s[j][i]; bit 3 stays 0 so a 2-bit index is always in range
  logic [2:0]      gnt_val_s;
  logic [2:0][1:0] gnt_s;
  logic [2:0]      in_rdy_s;
  logic [2:0]      out_val_s;
  logic [1:0]      cand_s;

  logic [2:0][1:0] ptr_r;
  logic [2:0]      held_r;
  logic [2:0][1:0] hgnt_r;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    case (x)
      2'd0:    inc3 = 2'd1;
      2'd1:    inc3 = 2'd2;
      default: inc3 = 2'd0;
    endcase
  endfunction

  assign val_s     = {in2_val, in1_val, in0_val};
  assign dest_s    = {in2_dest, in1_dest, in0_dest};
  assign out_rdy_s = {out2_rdy, out1_rdy, out0_rdy};

  // Request matrix and per-output grant: a live lock wins, else round-robin from ptr
  always_comb begin
    req_s     = '0;
    gnt_val_s = 3'b000;
    gnt_s     = '0;
    cand_s    = 2'd0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) begin
        req_s[j][i] = val_s[i] && (dest_s[i] == j[1:0]);
      end
      if (held_r[j] && req_s[j][hgnt_r[j]]) begin
        gnt_val_s[j] = 1'b1;
        gnt_s[j]     = hgnt_r[j];
      end else begin
        cand_s = ptr_r[j];
        for (int k = 0; k < 3; k++) begin
          if (!gnt_val_s[j] && req_s[j][cand_s]) begin
            gnt_val_s[j] = 1'b1;
            gnt_s[j]     = cand_s;
          end else begin
            gnt_val_s[j] = gnt_val_s[j];
          end
          cand_s = inc3(cand_s);
        end
      end
    end
  end

  // Input ready: the output this input targets grants it and is accepting
  always_comb begin
    in_rdy_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        in_rdy_s[i] = in_rdy_s[i] |
                      (!reset && gnt_val_s[j] && out_rdy_s[j] && (gnt_s[j] == i[1:0]));
      end
    end
  end

  assign out_val_s = reset ? 3'b000 : gnt_val_s;

  assign in0_rdy  = in_rdy_s[0];
  assign in1_rdy  = in_rdy_s[1];
  assign in2_rdy  = in_rdy_s[2];
  assign out0_val = out_val_s[0];
  assign out1_val = out_val_s[1];
  assign out2_val = out_val_s[2];
  assign sel0     = reset ? 2'd0 : gnt_s[0];
  assign sel1     = reset ? 2'd0 : gnt_s[1];
  assign sel2     = reset ? 2'd0 : gnt_s[2];

  // Pointer advances past the winner on transfer; a stall locks the current grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r  <= '0;
      held_r <= 3'b000;
      hgnt_r <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (gnt_val_s[j] && out_rdy_s[j]) begin
          ptr_r[j]  <= inc3(gnt_s[j]);
          held_r[j] <= 1'b0;
        end else if (gnt_val_s[j]) begin
          held_r[j] <= 1'b1;
          hgnt_r[j] <= gnt_s[j];
        end else begin
          held_r[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/vc_crossbar3_arb.md
Name: vc_crossbar3_arb

Overview:
Arbitration and control stage that sits directly upstream of the 3x3 crossbar and drives its three select inputs. It accepts one val/rdy request per input port, each tagged with a destination output, and runs an independent round-robin arbiter per output. A sticky-grant rule keeps each output's selection stable until its message is accepted. Payload and domain tags bypass this block and go straight to the crossbar; only control passes through here.

Parameters:
p_num_ports, 3, number of input and output ports; fixed at 3, with any other value rejected at elaboration.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in0_val / in1_val / in2_val  input  1 each  request valid for input i.
in0_dest / in1_dest / in2_dest  input  2 each  destination output (0..2) for input i; value 3 is illegal.
in0_rdy / in1_rdy / in2_rdy  output  1 each  input i message is accepted this cycle.
out0_val / out1_val / out2_val  output  1 each  output j carries a granted message.
out0_rdy / out1_rdy / out2_rdy  input  1 each  downstream of output j accepts.
sel0 / sel1 / sel2  output  2 each  crossbar select for output j (index of the granted input).

Behaviour:
- State per output j:
  - ptr_j: 2-bit priority pointer, range 0..2.
  - held_j: 1-bit flag, "grant is locked".
  - hgnt_j: 2 bits, the locked input index.
- Reset (asynchronous, while reset=1):
  - ptr_j=0, held_j=0, hgnt_j=0.
  - All out*_val=0, all in*_rdy=0, all sel*=2'd0, forced regardless of other inputs.
- Request matrix: req[i][j] = in_i_val && (in_i_dest==j). dest==3 never requests; that input's in_rdy stays 0 indefinitely (no drop, no error flag).
- Grant for output j is combinational, zero-cycle latency, no internal buffering:
  - If held_j and req[hgnt_j][j]: grant=hgnt_j. Lock wins over every other request.
  - Otherwise: first i with req[i][j], scanning ptr_j, ptr_j+1, ptr_j+2 (mod 3).
  - If no request: no grant.
- Outputs:
  - outj_val = 1 iff output j has a grant.
  - selj = granted index; 2'd0 when idle. Selj never takes 2'd3.
  - in_i_rdy = outj_rdy && grant_j==i, where j=in_i_dest. This is a combinational rdy-to-rdy path.
  - Each input requests only one output, so at most one grant can reference it.
- Sequential update per output j on the clock edge:
  - Transfer (outj_val && outj_rdy): ptr_j <= (grant+1) mod 3, held_j <= 0.
  - Stall (outj_val && !outj_rdy): held_j <= 1, hgnt_j <= grant, ptr_j unchanged.
  - Idle: ptr_j and held_j unchanged except held_j <= 0. Idle can only occur when the locked requester withdrew.
- Protocol rules:
  - Upstream must hold val and dest stable until rdy.
  - If a locked requester drops val anyway, the lock is ignored that cycle, fresh round-robin arbitration applies, and held_j clears at the edge.
- Independence: the three outputs arbitrate fully in parallel. Multiple inputs to different outputs transfer in the same cycle; up to 3 transfers per cycle.
- Reset asserted mid-stall clears locks immediately. After reset deassertion, arbitration restarts from ptr=0.
- Combinational outputs have no X-propagation from illegal dest; idle defaults apply.

Test Plan:
1. Reset and idle: reset=1 with all val=1 and all out_rdy=1 -> all out_val=0, all in_rdy=0, sel=0. Release reset with all val=0 -> outputs stay 0.
2. Parallel permutation: in0->dest2, in1->dest0, in2->dest1, all out_rdy=1 -> sel0=1, sel1=2, sel2=0, all three out_val=1 and in_rdy=1 in the same cycle.
3. Round-robin fairness: all three inputs target output 0 continuously with out0_rdy=1 -> grants 0,1,2,0,1,2 on consecutive cycles. in_rdy pulses one-hot in the same order.
4. Sticky grant: all target output 1, out1_rdy=0 for 4 cycles -> sel1=0 and out1_val=1 held every cycle, no in_rdy asserted. On out1_rdy=1, in0_rdy=1 that cycle, next grant is input 1.
5. Illegal dest and withdrawal: in2_dest=3 with in2_val=1 -> in2_rdy=0 forever, no out_val. Stall output 2 on input 1, then drop in1_val -> output 2 re-arbitrates to a waiting input 0 that same cycle.
6. Async reset mid-stall: output 0 locked on input 2, assert reset between edges -> out0_val falls without waiting for an edge. After release, 3 requesters to output 0 are granted input 0 first.
